// File: rtl/edge_event_arbiter.sv
// Buffers one edge event per channel and serialises pending events round-robin
// onto a single registered valid/ready stream, with sticky per-channel overflow.
module edge_event_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic            CLK_I,
  input  logic            RST_ASYNC_I,
  input  logic [N_CH-1:0] REDGE_I,
  input  logic [N_CH-1:0] FEDGE_I,
  input  logic [N_CH-1:0] EN_RISE_I,
  input  logic [N_CH-1:0] EN_FALL_I,
  input  logic            CLR_I,
  output logic            EVT_VALID_O,
  input  logic            EVT_READY_I,
  output logic [CH_W-1:0] EVT_CH_O,
  output logic            EVT_FALL_O,
  output logic [N_CH-1:0] PENDING_O,
  output logic [N_CH-1:0] OVF_O
);

  // Stream handshake: an event transfers on the rising edge where
  // EVT_VALID_O and EVT_READY_I are both high; while valid is high and ready
  // is low, EVT_VALID_O/EVT_CH_O/EVT_FALL_O hold stable.

  localparam logic [CH_W-1:0] LAST_RST = CH_W'(N_CH - 1);
  localparam logic [CH_W:0]   N_CH_EXT = (CH_W + 1)'(N_CH);

  logic [N_CH-1:0] occ_q, occ_d;
  logic [N_CH-1:0] typ_q, typ_d;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic            evt_valid_q, evt_valid_d;
  logic [CH_W-1:0] evt_ch_q, evt_ch_d;
  logic            evt_fall_q, evt_fall_d;
  logic [CH_W-1:0] last_q, last_d;

  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic            load;
  logic            gnt_found;
  logic [CH_W-1:0] gnt_ch;
  logic            gnt_fire;

  assign rise     = REDGE_I & EN_RISE_I;
  assign fall     = FEDGE_I & EN_FALL_I;
  assign load     = ~evt_valid_q | EVT_READY_I;
  assign gnt_fire = load & gnt_found;

  // Walk the search order backwards so the nearest channel after last_q wins.
  always_comb begin
    logic [CH_W:0] sum;
    gnt_found = 1'b0;
    gnt_ch    = '0;
    sum       = '0;
    for (int k = N_CH; k >= 1; k--) begin
      sum = {1'b0, last_q} + (CH_W + 1)'(k);
      if (sum >= N_CH_EXT) begin
        sum = sum - N_CH_EXT;
      end
      if (occ_q[sum[CH_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_ch    = sum[CH_W-1:0];
      end
    end
  end

  always_comb begin
    logic granted;
    occ_d       = occ_q;
    typ_d       = typ_q;
    ovf_d       = ovf_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_fall_d  = evt_fall_q;
    last_d      = last_q;
    granted     = 1'b0;

    if (load) begin
      evt_valid_d = gnt_found;
      if (gnt_found) begin
        evt_ch_d   = gnt_ch;
        evt_fall_d = typ_q[gnt_ch];
        last_d     = gnt_ch;
      end
    end

    for (int ch = 0; ch < N_CH; ch++) begin
      granted = gnt_fire && (gnt_ch == CH_W'(ch));
      if (granted) begin
        occ_d[ch] = 1'b0;
      end
      // A slot emptied by this cycle's grant can take a new event directly.
      if (rise[ch] || fall[ch]) begin
        if (occ_q[ch] && !granted) begin
          ovf_d[ch] = 1'b1;
        end else begin
          occ_d[ch] = 1'b1;
          typ_d[ch] = ~rise[ch];
          if (rise[ch] && fall[ch]) begin
            ovf_d[ch] = 1'b1;
          end
        end
      end
    end

    if (CLR_I) begin
      occ_d       = '0;
      typ_d       = '0;
      ovf_d       = '0;
      evt_valid_d = 1'b0;
      evt_ch_d    = '0;
      evt_fall_d  = 1'b0;
      last_d      = LAST_RST;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_ASYNC_I) begin
    if (RST_ASYNC_I) begin
      occ_q       <= '0;
      typ_q       <= '0;
      ovf_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_fall_q  <= 1'b0;
      last_q      <= LAST_RST;
    end else begin
      occ_q       <= occ_d;
      typ_q       <= typ_d;
      ovf_q       <= ovf_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_fall_q  <= evt_fall_d;
      last_q      <= last_d;
    end
  end

  assign EVT_VALID_O = evt_valid_q;
  assign EVT_CH_O    = evt_ch_q;
  assign EVT_FALL_O  = evt_fall_q;
  assign PENDING_O   = occ_q;
  assign OVF_O       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: cycle model compared every cycle, an
// expected-event queue for delivered events, and literal spot checks.
module tb_edge_event_arbiter;

  localparam int N    = 4;
  localparam int CH_W = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    redge, fedge, en_rise, en_fall;
  logic            clr, ready;
  logic            evt_valid, evt_fall;
  logic [CH_W-1:0] evt_ch;
  logic [N-1:0]    pending, ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [CH_W:0] exp_q[$];

  // behavioural model state
  int m_occ[N], m_fall[N], m_ovf[N];
  int m_valid, m_ch, m_efall, m_last;

  edge_event_arbiter #(.N_CH(N), .CH_W(CH_W)) dut (
    .CLK_I(clk), .RST_ASYNC_I(rst),
    .REDGE_I(redge), .FEDGE_I(fedge),
    .EN_RISE_I(en_rise), .EN_FALL_I(en_fall),
    .CLR_I(clr),
    .EVT_VALID_O(evt_valid), .EVT_READY_I(ready),
    .EVT_CH_O(evt_ch), .EVT_FALL_O(evt_fall),
    .PENDING_O(pending), .OVF_O(ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model
  task automatic m_reset();
    for (int c = 0; c < N; c++) begin
      m_occ[c] = 0; m_fall[c] = 0; m_ovf[c] = 0;
    end
    m_valid = 0; m_ch = 0; m_efall = 0; m_last = N - 1;
  endtask

  task automatic m_step();
    int g;
    int rr, ff;
    if (clr) begin
      m_reset();
      return;
    end
    g = -1;
    if (m_valid == 0 || ready) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (g < 0 && m_occ[c] != 0) g = c;
      end
      if (g >= 0) begin
        m_valid = 1; m_ch = g; m_efall = m_fall[g];
        m_occ[g] = 0; m_last = g;
      end else begin
        m_valid = 0;
      end
    end
    for (int c = 0; c < N; c++) begin
      rr = int'(redge[c] & en_rise[c]);
      ff = int'(fedge[c] & en_fall[c]);
      if (rr != 0 || ff != 0) begin
        if (m_occ[c] != 0) begin
          m_ovf[c] = 1;
        end else begin
          m_occ[c] = 1;
          m_fall[c] = (rr != 0) ? 0 : 1;
          if (rr != 0 && ff != 0) m_ovf[c] = 1;
        end
      end
    end
  endtask

  function automatic int vec(input int a[N]);
    int v;
    v = 0;
    for (int c = 0; c < N; c++) if (a[c] != 0) v |= (1 << c);
    return v;
  endfunction

  // compare process + scoreboard
  always @(negedge clk) begin
    if (rst) m_reset();
    chk("mdl_valid", int'(evt_valid), m_valid);
    if (m_valid != 0) begin
      chk("mdl_ch", int'(evt_ch), m_ch);
      chk("mdl_fall", int'(evt_fall), m_efall);
    end
    chk("mdl_pending", int'(pending), vec(m_occ));
    chk("mdl_ovf", int'(ovf), vec(m_ovf));
    if (!rst) begin
      if (evt_valid && ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_evt", int'({evt_fall, evt_ch}), -1);
        end else begin
          chk("sb_evt", int'({evt_fall, evt_ch}), int'(exp_q.pop_front()));
        end
      end
      m_step();
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
    redge = '0; fedge = '0; clr = 1'b0;
  endtask

  task automatic push(input logic f, input logic [CH_W-1:0] ch);
    exp_q.push_back({f, ch});
  endtask

  task automatic drain(input string name);
    int done;
    done = 0;
    for (int i = 0; i < 30 && done == 0; i++) begin
      cyc();
      #5;
      if (exp_q.size() == 0 && !evt_valid) done = 1;
    end
    chk(name, done, 1);
  endtask

  initial begin
    rst = 1'b1; redge = '0; fedge = '0; clr = 1'b0; ready = 1'b0;
    en_rise = '1; en_fall = '1;
    repeat (2) @(posedge clk);
    cyc(); rst = 1'b0;

    // single rising event on ch0: pending in c1, valid only in c2
    cyc(); ready = 1'b1; redge = 4'b0001; push(1'b0, 2'd0);
    #5 chk("rst_valid", int'(evt_valid), 0);
    chk("rst_pending", int'(pending), 0);
    cyc(); #5 chk("t1_pend_c1", int'(pending), 4'b0001);
    chk("t1_valid_c1", int'(evt_valid), 0);
    cyc(); #5 chk("t1_valid_c2", int'(evt_valid), 1);
    chk("t1_ch_c2", int'(evt_ch), 0);
    chk("t1_fall_c2", int'(evt_fall), 0);
    chk("t1_pend_c2", int'(pending), 0);
    cyc(); #5 chk("t1_valid_c3", int'(evt_valid), 0);

    // all falling after clear: ch0..ch3 back to back
    cyc(); clr = 1'b1;
    cyc(); fedge = 4'b1111;
    push(1'b1, 2'd0); push(1'b1, 2'd1); push(1'b1, 2'd2); push(1'b1, 2'd3);
    cyc(); #5 chk("t2_pend", int'(pending), 4'b1111);
    cyc(); #5 chk("t2_ch_a", int'(evt_ch), 0);
    chk("t2_pend_a", int'(pending), 4'b1110);
    cyc(); #5 chk("t2_ch_b", int'(evt_ch), 1);
    chk("t2_fall_b", int'(evt_fall), 1);
    drain("t2_drain");

    // grant ch2, then all falling wraps: 3,0,1,2
    cyc(); redge = 4'b0100; push(1'b0, 2'd2);
    drain("t3a_drain");
    cyc(); fedge = 4'b1111;
    push(1'b1, 2'd3); push(1'b1, 2'd0); push(1'b1, 2'd1); push(1'b1, 2'd2);
    cyc(); cyc(); #5 chk("t3_first_ch", int'(evt_ch), 3);
    drain("t3_drain");

    // stalled stream: second ch1 pulse overflows, ch1 delivered once
    cyc(); ready = 1'b0; redge = 4'b0001; push(1'b0, 2'd0); push(1'b0, 2'd1);
    cyc(); cyc();
    cyc(); redge = 4'b0010;
    cyc(); redge = 4'b0010;
    cyc(); #5 chk("t4_ovf", int'(ovf), 4'b0010);
    chk("t4_pend", int'(pending), 4'b0010);
    chk("t4_hold_ch", int'(evt_ch), 0);
    cyc(); ready = 1'b1;
    drain("t4_drain");
    chk("t4_ovf_sticky", int'(ovf), 4'b0010);
    cyc(); clr = 1'b1;
    cyc(); #5 chk("t4_ovf_clr", int'(ovf), 0);

    // simultaneous rise+fall on ch2; disabled fall on ch3
    cyc(); en_fall = 4'b0111; redge = 4'b0100; fedge = 4'b1100; push(1'b0, 2'd2);
    cyc(); #5 chk("t5_ovf", int'(ovf), 4'b0100);
    chk("t5_pend", int'(pending), 4'b0100);
    drain("t5_drain");
    cyc(); clr = 1'b1; en_fall = 4'b1111;

    // new ch0 event in the cycle its slot is granted: no overflow
    cyc(); redge = 4'b0001; push(1'b0, 2'd0); push(1'b0, 2'd0);
    cyc(); redge = 4'b0001;
    cyc(); #5 chk("t6_pend", int'(pending), 4'b0001);
    chk("t6_valid", int'(evt_valid), 1);
    drain("t6_drain");
    chk("t6_ovf", int'(ovf), 0);

    // clear with events pending
    cyc(); ready = 1'b0; fedge = 4'b1111;
    cyc(); cyc(); #5 chk("t7_valid_pre", int'(evt_valid), 1);
    cyc(); clr = 1'b1;
    cyc(); #5 chk("t7_valid", int'(evt_valid), 0);
    chk("t7_pend", int'(pending), 0);
    chk("t7_ch", int'(evt_ch), 0);
    chk("t7_fall", int'(evt_fall), 0);

    // asynchronous reset mid-operation
    cyc(); fedge = 4'b1111;
    cyc(); cyc(); #5 chk("t8_pend_pre", int'(pending), 4'b1110);
    cyc(); rst = 1'b1;
    #1 chk("t8_valid", int'(evt_valid), 0);
    chk("t8_pend", int'(pending), 0);
    chk("t8_ovf", int'(ovf), 0);
    cyc(); rst = 1'b0;
    cyc(); #5 chk("t8_valid_after", int'(evt_valid), 0);

    chk("sb_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
